memoria_loader: RTL and testbench

Initiator-side writer for the 32-bit, 600-word instruction/data memory: loads a program image into memory at run time instead of relying on the preloaded initial contents. A byte stream with a valid/ready handshake is packed into 32-bit words. Each word is written through the memory's dado/endereco/write port and, optionally, read back through saida for checking. It sits between a host/boot byte source and the memory; the processor is held off while busy=1.

---
 rtl/memoria_loader_pkg.sv | 29 ++
 rtl/memoria_loader_packer.sv | 35 +++
 rtl/memoria_loader.sv | 134 +++++++++++++
 tb/tb_memoria_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/memoria_loader_pkg.sv
// Shared constants, state encoding and write-port payload for the program loader.
package memoria_loader_pkg;

  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEPTH          = 600;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;

  // Highest address the memory actually implements
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // One memory write beat: address plus data
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

endpackage

// File: rtl/memoria_loader_packer.sv
// Big-endian 8-to-32 packer: first byte of a word lands in bits [31:24].
module memoria_loader_packer
  import memoria_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_take,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [DATA_W-1:0] o_word_c,
  output logic              o_word_full_c
);

  // Only the three earlier bytes need storage; the fourth arrives with word_full
  logic [DATA_W-BYTE_W-1:0] r_word;
  logic [IDX_W-1:0]         r_byte_idx;

  // Shift accepted bytes in and count modulo 4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_clear) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_take) begin
      r_word     <= {r_word[DATA_W-2*BYTE_W-1:0], i_byte};
      r_byte_idx <= r_byte_idx + IDX_W'(1);
    end
  end

  assign o_word_c      = {r_word, i_byte};
  assign o_word_full_c = i_take && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/memoria_loader.sv
// Loads a byte-streamed program image into the instruction/data memory, with optional read-back check.
module memoria_loader
  import memoria_loader_pkg::*;
#(
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] saida,
  output logic [DATA_W-1:0] dado,
  output logic [ADDR_W-1:0] endereco,
  output logic              write,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;
  logic [ADDR_W-1:0] r_words;
  mem_wr_t           r_wr;
  logic              r_byte_ready;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              w_take;
  logic              w_start;
  logic              w_commit;
  logic              w_full;
  logic [DATA_W-1:0] w_word;

  // A byte moves only while the registered ready is up
  assign w_take = r_byte_ready && byte_valid;

  memoria_loader_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (w_start),
    .i_take        (w_take),
    .i_byte        (byte_in),
    .o_word_c      (w_word),
    .o_word_full_c (w_full)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; commit covers both the no-verify and verify-match exits
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_start     = 1'b1;
          w_state_nxt = (length == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        // Overflow is caught before the write so no wrapped address reaches memory
        if (w_full) w_state_nxt = (r_addr > LAST_ADDR) ? ST_ERROR : ST_WRITE;
      end
      ST_WRITE: begin
        if (VERIFY) w_state_nxt = ST_VERIFY;
        else        w_commit    = 1'b1;
      end
      ST_VERIFY: begin
        if (saida != r_wr.data) w_state_nxt = ST_ERROR;
        else                    w_commit    = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_commit) w_state_nxt = (r_remaining == ADDR_W'(1)) ? ST_DONE : ST_RECV;
  end

  // Registered outputs follow the next state; address/counter bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_ready <= 1'b0;
      r_write      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_words      <= '0;
      r_wr         <= '0;
    end else begin
      r_byte_ready <= (w_state_nxt == ST_RECV);
      r_write      <= (w_state_nxt == ST_WRITE);
      r_busy       <= (w_state_nxt inside {ST_RECV, ST_WRITE, ST_VERIFY});
      r_done       <= (w_state_nxt == ST_DONE);
      r_error      <= (w_state_nxt == ST_ERROR);
      if (w_start) begin
        r_addr      <= base_addr;
        r_remaining <= length;
        r_words     <= '0;
      end
      if (w_full && (w_state_nxt == ST_WRITE)) begin
        r_wr.addr <= r_addr;
        r_wr.data <= w_word;
      end
      if (w_commit) begin
        r_words     <= r_words + ADDR_W'(1);
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - ADDR_W'(1);
      end
    end
  end

  assign byte_ready    = r_byte_ready;
  assign write         = r_write;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign dado          = r_wr.data;
  assign endereco      = r_wr.addr;
  assign words_written = r_words;

endmodule

// File: tb/tb_memoria_loader.sv
// Bench for memoria_loader: memory model, expected-write scoreboard and randomized byte streams.
module tb_memoria_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  length;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] saida;
  logic [31:0] dado;
  logic [9:0]  endereco;
  logic        write;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  words_written;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:599];
  logic [31:0] words_in [$];
  int          exp_addr [$];
  logic [31:0] exp_data [$];
  int          wr_total = 0;
  int          wr_base  = 0;
  int          bad_idx  = -1;

  memoria_loader #(.VERIFY(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .saida         (saida),
    .dado          (dado),
    .endereco      (endereco),
    .write         (write),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory commits on the posedge closing the write cycle
  always @(posedge clk) begin
    if (rst_n && write && (endereco < 10'd600)) mem[endereco] <= dado;
  end

  // Scoreboard of write beats, per-cycle invariants, and read port (optionally corrupted)
  always @(negedge clk) begin
    if (rst_n) begin
      if (write) begin
        wr_total++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write at addr %0d data 0x%0h, required no write", endereco, dado);
        end else begin
          int          ea;
          logic [31:0] ed;
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          check("write_addr", 32'(endereco), 32'(ea));
          check("write_data", dado, ed);
        end
      end
      check("ready_during_write", 32'(write & byte_ready), 32'd0);
      check("busy_with_status", 32'(busy & (done | error)), 32'd0);
      check("done_and_error", 32'(done & error), 32'd0);
      check("ready_without_busy", 32'(byte_ready & ~busy), 32'd0);
    end
    if (bad_idx >= 0 && (wr_total - wr_base) == bad_idx + 1) saida = 32'hDEADBEEF;
    else if (endereco < 10'd600) saida = mem[endereco];
    else saida = 32'h0;
  end

  // One load: model predicts writes/status from the word list, then the stream is driven
  task automatic run_load(input int base, input int len, input int bad, input int rate,
                          input bit inject, input bit abort, output int cyc_out);
    logic [7:0] bytes [$];
    int  ntry, exp_words, nbytes, k, cyc;
    bit  exp_err, hs, finished;
    while (words_in.size() < len) words_in.push_back($urandom);
    ntry = 0; exp_words = 0; exp_err = 1'b0;
    for (int i = 0; i < len; i++) begin
      ntry++;
      for (int b = 0; b < 4; b++) bytes.push_back(8'(words_in[i] >> (24 - 8 * b)));
      if (base + i > 599) begin exp_err = 1'b1; break; end
      exp_addr.push_back(base + i);
      exp_data.push_back(words_in[i]);
      if (i == bad) begin exp_err = 1'b1; break; end
      exp_words++;
    end
    nbytes = 4 * ntry;
    words_in.delete();
    bad_idx = bad;
    wr_base = wr_total;
    @(negedge clk);
    start = 1'b1; base_addr = 10'(base); length = 10'(len); byte_valid = 1'b0;
    hs = 1'b0; k = 0; finished = 1'b0;
    for (cyc = 1; cyc <= 100 + len * 60; cyc++) begin
      @(negedge clk);
      start = inject && (cyc == 2);
      if (start) begin base_addr = 10'd700; length = 10'd1; end
      if (hs) begin
        if (k >= nbytes) check("extra_byte_taken", 32'(k), 32'(nbytes));
        else k++;
      end
      if (abort && write) begin finished = 1'b1; break; end
      if (done || error) begin finished = 1'b1; break; end
      if (k < nbytes) begin
        byte_valid = ($urandom_range(99) < rate);
        byte_in    = bytes[k];
      end else begin
        byte_valid = 1'($urandom_range(1));
        byte_in    = 8'($urandom);
      end
      hs = byte_valid && byte_ready;
    end
    start = 1'b0; byte_valid = 1'b0;
    cyc_out = cyc;
    if (!abort) begin
      check("load_finished", 32'(finished), 32'd1);
      check("done", 32'(done), 32'(!exp_err));
      check("error", 32'(error), 32'(exp_err));
      check("words_written", 32'(words_written), 32'(exp_words));
      check("busy_at_end", 32'(busy), 32'd0);
      check("bytes_consumed", 32'(k), 32'(nbytes));
      check("writes_missing", 32'(exp_addr.size()), 32'd0);
      if (rate >= 100 && !exp_err) check("cycles_full_rate", 32'(cyc), 32'(1 + 6 * len));
      exp_addr.delete();
      exp_data.delete();
    end
  endtask

  initial begin
    int cyc, base, len, bad, rate;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; byte_in = '0; byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    rst_n = 1'b1;

    // Basic two-word load, literal expectations
    words_in.push_back(32'h0000002A); words_in.push_back(32'h12345678);
    run_load(0, 2, -1, 100, 1'b0, 1'b0, cyc);
    check("basic_cycles", 32'(cyc), 32'd13);
    check("basic_mem0", mem[0], 32'h0000002A);
    check("basic_mem1", mem[1], 32'h12345678);
    check("basic_words", 32'(words_written), 32'd2);

    // Throttled byte stream
    run_load(5, 1, -1, 40, 1'b0, 1'b0, cyc);

    // Overflow past the last address
    words_in.push_back(32'hA5A50001); words_in.push_back(32'hA5A50002);
    run_load(599, 2, -1, 100, 1'b0, 1'b0, cyc);
    check("ovf_mem599", mem[599], 32'hA5A50001);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_words", 32'(words_written), 32'd1);

    // Read-back mismatch
    words_in.push_back(32'h00000001);
    run_load(20, 1, 0, 100, 1'b0, 1'b0, cyc);
    check("mis_error", 32'(error), 32'd1);
    check("mis_words", 32'(words_written), 32'd0);

    // Zero length
    run_load(30, 0, -1, 100, 1'b0, 1'b0, cyc);
    check("len0_cycles", 32'(cyc), 32'd1);
    check("len0_done", 32'(done), 32'd1);

    // Start pulsed mid-receive is ignored
    run_load(40, 3, -1, 100, 1'b1, 1'b0, cyc);

    // Reset asserted during a write cycle
    run_load(10, 3, -1, 100, 1'b0, 1'b1, cyc);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_write", 32'(write), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    check("midrst_dado", dado, 32'd0);
    check("midrst_endereco", 32'(endereco), 32'd0);
    check("midrst_words", 32'(words_written), 32'd0);
    exp_addr.delete(); exp_data.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words_in.push_back(32'hCAFEF00D);
    run_load(0, 1, -1, 100, 1'b0, 1'b0, cyc);
    check("post_rst_mem0", mem[0], 32'hCAFEF00D);

    // Randomized loads, biased toward the top of memory
    for (int it = 0; it < 25; it++) begin
      base = ($urandom_range(2) == 0) ? 590 + $urandom_range(12) : $urandom_range(620);
      len  = $urandom_range(6);
      rate = $urandom_range(100, 30);
      bad  = (len > 0 && $urandom_range(4) == 0) ? $urandom_range(len - 1) : -1;
      run_load(base, len, bad, rate, 1'b0, 1'b0, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
